mem_wb_stage: RTL and testbench



---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/dmem_bytewise.sv | 24 ++
 rtl/mem_wb_stage.sv | 170 +++++++++++++++++
 tb/tb_mem_wb_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared encodings for the RISC-V pipeline: writeback select values,
// load/store size codes and the datapath width.
package pipeline_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WB_MEM = 2'b00,
    WB_ALU = 2'b01,
    WB_PC4 = 2'b10,
    WB_RSV = 2'b11
  } wbsel_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_bytewise.sv
// Word-organised data memory: asynchronous read, byte-enabled synchronous write.
// Contents are deliberately not reset.
module dmem_bytewise #(
  parameter int DMEM_AW = 10,
  parameter int XLEN    = 32
) (
  input  logic                clk,
  input  logic [XLEN/8-1:0]   byteEn,
  input  logic [DMEM_AW-1:0]  addr,
  input  logic [XLEN-1:0]     wrData,
  output logic [XLEN-1:0]     rdData
);

  logic [XLEN-1:0] mem [2**DMEM_AW];

  always_ff @(posedge clk) begin
    for (int i = 0; i < XLEN/8; i++) begin
      if (byteEn[i]) mem[addr][8*i +: 8] <= wrData[8*i +: 8];
    end
  end

  assign rdData = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// Back half of the pipeline: EX/MEM register, data memory access with lane
// select and load extension, MEM/WB register and writeback select.
module mem_wb_stage #(
  parameter int DMEM_AW = 10,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            regwriteE,
  input  logic            memrwE,
  input  logic [1:0]      wbselE,
  input  logic [2:0]      funct3E,
  input  logic [4:0]      rdE,
  input  logic [XLEN-1:0] alu_resultE,
  input  logic [XLEN-1:0] store_dataE,
  input  logic [XLEN-1:0] pc4E,
  output logic            regwriteM,
  output logic [4:0]      rdM,
  output logic [XLEN-1:0] alu_resultM,
  output logic            misalignM,
  output logic            regwriteW,
  output logic [4:0]      rdW,
  output logic [XLEN-1:0] resultW
);
  import pipeline_pkg::*;

  function automatic logic [XLEN-1:0] loadExtract(
    input logic [XLEN-1:0] word,
    input logic [2:0]      f3,
    input logic [1:0]      lane
  );
    logic        [7:0]  ub;
    logic        [15:0] uh;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    ub = word[8*lane +: 8];
    uh = lane[1] ? word[31:16] : word[15:0];
    sb = signed'(ub);
    sh = signed'(uh);
    case (f3)
      F3_B:    return XLEN'(sb);
      F3_H:    return XLEN'(sh);
      F3_BU:   return XLEN'(ub);
      F3_HU:   return XLEN'(uh);
      default: return word;
    endcase
  endfunction

  logic            regwrite_p1, memrw_p1;
  logic [1:0]      wbsel_p1;
  logic [2:0]      funct3_p1;
  logic [4:0]      rd_p1;
  logic [XLEN-1:0] aluResult_p1, storeData_p1, pc4_p1;

  logic            regwrite_p2;
  logic [1:0]      wbsel_p2;
  logic [4:0]      rd_p2;
  logic [XLEN-1:0] loadData_p2, aluResult_p2, pc4_p2;

  logic [1:0]        lane;
  logic              misalign;
  logic [XLEN/8-1:0] byteEn;
  logic [XLEN-1:0]   wrData, rdWord, loadData;

  // ---- EX/MEM boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_p1  <= 1'b0;
      memrw_p1     <= 1'b0;
      wbsel_p1     <= '0;
      funct3_p1    <= '0;
      rd_p1        <= '0;
      aluResult_p1 <= '0;
      storeData_p1 <= '0;
      pc4_p1       <= '0;
    end else begin
      regwrite_p1  <= regwriteE;
      memrw_p1     <= memrwE;
      wbsel_p1     <= wbselE;
      funct3_p1    <= funct3E;
      rd_p1        <= rdE;
      aluResult_p1 <= alu_resultE;
      storeData_p1 <= store_dataE;
      pc4_p1       <= pc4E;
    end
  end

  assign lane = aluResult_p1[1:0];

  always_comb begin
    misalign = 1'b0;
    if ((wbsel_p1 == WB_MEM) || memrw_p1) begin
      case (funct3_p1)
        F3_H, F3_HU: misalign = lane[0];
        F3_W:        misalign = |lane;
        default:     misalign = 1'b0;
      endcase
    end
  end

  // Misaligned or unknown-size stores leave memory untouched.
  always_comb begin
    byteEn = '0;
    wrData = storeData_p1;
    if (memrw_p1 && !misalign) begin
      case (funct3_p1)
        F3_B: begin
          byteEn = 4'b0001 << lane;
          wrData = {4{storeData_p1[7:0]}};
        end
        F3_H: begin
          byteEn = lane[1] ? 4'b1100 : 4'b0011;
          wrData = {2{storeData_p1[15:0]}};
        end
        F3_W:    byteEn = 4'b1111;
        default: byteEn = '0;
      endcase
    end
  end

  dmem_bytewise #(
    .DMEM_AW(DMEM_AW),
    .XLEN   (XLEN)
  ) u_dmem (
    .clk   (clk),
    .byteEn(byteEn),
    .addr  (aluResult_p1[DMEM_AW+1:2]),
    .wrData(wrData),
    .rdData(rdWord)
  );

  assign loadData = loadExtract(rdWord, funct3_p1, lane);

  // ---- MEM/WB boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_p2  <= 1'b0;
      wbsel_p2     <= '0;
      rd_p2        <= '0;
      loadData_p2  <= '0;
      aluResult_p2 <= '0;
      pc4_p2       <= '0;
    end else begin
      regwrite_p2  <= regwrite_p1;
      wbsel_p2     <= wbsel_p1;
      rd_p2        <= rd_p1;
      loadData_p2  <= loadData;
      aluResult_p2 <= aluResult_p1;
      pc4_p2       <= pc4_p1;
    end
  end

  always_comb begin
    resultW = '0;
    case (wbsel_p2)
      WB_MEM:  resultW = loadData_p2;
      WB_ALU:  resultW = aluResult_p2;
      WB_PC4:  resultW = pc4_p2;
      default: resultW = '0;
    endcase
  end

  assign regwriteM   = regwrite_p1;
  assign rdM         = rd_p1;
  assign alu_resultM = aluResult_p1;
  assign misalignM   = misalign;
  assign regwriteW   = regwrite_p2;
  assign rdW         = rd_p2;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: stimulus queues expected M/W responses,
// a negedge monitor pops and compares them when they fall due.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        regwriteE, memrwE;
  logic [1:0]  wbselE;
  logic [2:0]  funct3E;
  logic [4:0]  rdE;
  logic [31:0] alu_resultE, store_dataE, pc4E;
  logic        regwriteM, misalignM, regwriteW;
  logic [4:0]  rdM, rdW;
  logic [31:0] alu_resultM, resultW;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          due;
    logic        rw;
    logic [4:0]  rd;
    logic        chk;
    logic [31:0] res;
  } wexp_t;

  typedef struct {
    int   due;
    logic mis;
  } mexp_t;

  wexp_t wq[$];
  mexp_t mq[$];
  wexp_t w;
  mexp_t m;

  mem_wb_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .regwriteE  (regwriteE),
    .memrwE     (memrwE),
    .wbselE     (wbselE),
    .funct3E    (funct3E),
    .rdE        (rdE),
    .alu_resultE(alu_resultE),
    .store_dataE(store_dataE),
    .pc4E       (pc4E),
    .regwriteM  (regwriteM),
    .rdM        (rdM),
    .alu_resultM(alu_resultM),
    .misalignM  (misalignM),
    .regwriteW  (regwriteW),
    .rdW        (rdW),
    .resultW    (resultW)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      while (mq.size() > 0 && mq[0].due < cyc) begin
        check("misalign_missed", 32'(mq[0].due), 32'(cyc));
        void'(mq.pop_front());
      end
      if (mq.size() > 0 && mq[0].due == cyc) begin
        m = mq.pop_front();
        check("misalignM", 32'(misalignM), 32'(m.mis));
      end
      while (wq.size() > 0 && wq[0].due < cyc) begin
        check("wb_missed", 32'(wq[0].due), 32'(cyc));
        void'(wq.pop_front());
      end
      if (wq.size() > 0 && wq[0].due == cyc) begin
        w = wq.pop_front();
        check($sformatf("regwriteW rd%0d", w.rd), 32'(regwriteW), 32'(w.rw));
        check($sformatf("rdW rd%0d", w.rd), 32'(rdW), 32'(w.rd));
        if (w.chk) check($sformatf("resultW rd%0d", w.rd), resultW, w.res);
      end else if (regwriteW) begin
        check("unexpected_regwriteW", 32'(regwriteW), 32'd0);
      end
    end
  end

  task automatic drive(input logic rw, input logic mrw, input logic [1:0] ws,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pc4);
    regwriteE   = rw;
    memrwE      = mrw;
    wbselE      = ws;
    funct3E     = f3;
    rdE         = rd;
    alu_resultE = alu;
    store_dataE = sd;
    pc4E        = pc4;
  endtask

  task automatic issue(input logic rw, input logic mrw, input logic [1:0] ws,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pc4,
                       input logic chk, input logic [31:0] expRes, input logic expMis);
    drive(rw, mrw, ws, f3, rd, alu, sd, pc4);
    mq.push_back('{due: cyc + 1, mis: expMis});
    wq.push_back('{due: cyc + 2, rw: rw, rd: rd, chk: chk, res: expRes});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                       input logic mis);
    issue(1'b0, 1'b1, 2'b01, f3, 5'd0, addr, data, 32'd0, 1'b0, 32'd0, mis);
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                      input logic [31:0] exp, input logic mis);
    issue(1'b1, 1'b0, 2'b00, f3, rd, addr, 32'd0, 32'd0, 1'b1, exp, mis);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 2'b00, 3'b001, 5'd7, 32'h0000_0101, 32'hFFFF_FFFF, 32'h4);
    repeat (2) begin
      @(negedge clk);
      check("rst regwriteM", 32'(regwriteM), 32'd0);
      check("rst misalignM", 32'(misalignM), 32'd0);
      check("rst regwriteW", 32'(regwriteW), 32'd0);
      check("rst rdW", 32'(rdW), 32'd0);
      check("rst resultW", resultW, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    issue(1'b1, 1'b0, 2'b01, 3'b000, 5'd5, 32'h1234_5678, 32'd0, 32'd0, 1'b1, 32'h1234_5678, 1'b0);

    store(3'b010, 32'h100, 32'hAABB_CCDD, 1'b0);
    store(3'b000, 32'h101, 32'h0000_007F, 1'b0);
    load (3'b010, 32'h100, 5'd10, 32'hAABB_7FDD, 1'b0);
    load (3'b000, 32'h103, 5'd11, 32'hFFFF_FFAA, 1'b0);
    load (3'b100, 32'h103, 5'd12, 32'h0000_00AA, 1'b0);
    load (3'b000, 32'h101, 5'd13, 32'h0000_007F, 1'b0);

    store(3'b001, 32'h202, 32'h0000_8001, 1'b0);
    load (3'b001, 32'h202, 5'd14, 32'hFFFF_8001, 1'b0);
    load (3'b101, 32'h202, 5'd15, 32'h0000_8001, 1'b0);

    store(3'b010, 32'h300, 32'h5566_7788, 1'b0);
    store(3'b010, 32'h301, 32'h1111_1111, 1'b1);
    load (3'b010, 32'h300, 5'd16, 32'h5566_7788, 1'b0);
    load (3'b001, 32'h303, 5'd17, 32'h0000_5566, 1'b1);
    store(3'b001, 32'h301, 32'h0000_BEEF, 1'b1);
    load (3'b010, 32'h302, 5'd18, 32'h5566_7788, 1'b1);
    store(3'b000, 32'h302, 32'h0000_0099, 1'b0);
    load (3'b010, 32'h300, 5'd19, 32'h5599_7788, 1'b0);

    issue(1'b1, 1'b0, 2'b10, 3'b000, 5'd1, 32'h999, 32'd0, 32'h44, 1'b1, 32'h44, 1'b0);
    issue(1'b1, 1'b0, 2'b11, 3'b000, 5'd2, 32'h55, 32'd0, 32'h88, 1'b1, 32'h0, 1'b0);
    issue(1'b1, 1'b0, 2'b01, 3'b000, 5'd0, 32'h77, 32'd0, 32'd0, 1'b1, 32'h77, 1'b0);
    issue(1'b1, 1'b0, 2'b01, 3'b001, 5'd6, 32'h3, 32'd0, 32'd0, 1'b1, 32'h3, 1'b0);

    store(3'b010, 32'h1000, 32'hCAFE_F00D, 1'b0);
    load (3'b010, 32'h0, 5'd3, 32'hCAFE_F00D, 1'b0);

    store(3'b010, 32'h500, 32'h0A0B_0C0D, 1'b0);
    store(3'b011, 32'h500, 32'hFFFF_FFFF, 1'b0);
    load (3'b010, 32'h500, 5'd4, 32'h0A0B_0C0D, 1'b0);

    store(3'b010, 32'h400, 32'h0102_0304, 1'b0);
    idle();
    idle();
    drive(1'b0, 1'b1, 2'b01, 3'b010, 5'd9, 32'h400, 32'hFFFF_FFFF, 32'd0);
    @(posedge clk);
    #1;
    check("pre-reset rdM", 32'(rdM), 32'd9);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0);
    #1;
    check("async rdM", 32'(rdM), 32'd0);
    check("async alu_resultM", alu_resultM, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("midrst regwriteW", 32'(regwriteW), 32'd0);
      check("midrst resultW", resultW, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    load(3'b010, 32'h400, 5'd7, 32'h0102_0304, 1'b0);

    repeat (4) idle();
    check("wb queue drained", 32'(wq.size()), 32'd0);
    check("misalign queue drained", 32'(mq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got %0d want finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
